// File: rtl/mem_ls_ctrl_pkg.sv
// rtl/mem_ls_ctrl_pkg.sv - access-type and FSM state encodings shared by the load/store controller
package mem_ls_ctrl_pkg;

    localparam logic [2:0] LS_W  = 3'd0;
    localparam logic [2:0] LS_H  = 3'd1;
    localparam logic [2:0] LS_HU = 3'd2;
    localparam logic [2:0] LS_B  = 3'd3;
    localparam logic [2:0] LS_BU = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } ls_state_e;

    function automatic logic ls_is_half(input logic [2:0] t);
        return (t == LS_H) || (t == LS_HU);
    endfunction

    function automatic logic ls_is_byte(input logic [2:0] t);
        return (t == LS_B) || (t == LS_BU);
    endfunction

endpackage

// File: rtl/mem_ls_ctrl_ls_align.sv
// rtl/mem_ls_ctrl_ls_align.sv - combinational misalign check, byte-enable/write-lane generation and load extension
module mem_ls_ctrl_ls_align
    import mem_ls_ctrl_pkg::*;
(
    input  logic [2:0]  req_type,
    input  logic        req_we,
    input  logic [1:0]  req_addr_lo,
    input  logic [31:0] req_data,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Unknown type codes fall through to word behaviour.
    always_comb begin
        misaligned = 1'b0;
        be         = 4'b1111;
        wdata      = req_data;
        if (ls_is_byte(req_type)) begin
            be    = 4'b0001 << req_addr_lo;
            wdata = {4{req_data[7:0]}};
        end else if (ls_is_half(req_type)) begin
            misaligned = req_addr_lo[0];
            be         = req_addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata      = {2{req_data[15:0]}};
        end else begin
            misaligned = |req_addr_lo;
        end
        if (!req_we) begin
            wdata = '0;
        end
    end

    always_comb begin
        byte_sel = rdata[7:0];
        case (ld_addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (ld_type)
            LS_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            LS_BU:   ld_data = {24'd0, byte_sel};
            LS_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            LS_HU:   ld_data = {16'd0, half_sel};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_ls_ctrl.sv
// rtl/mem_ls_ctrl.sv - MEM-stage load/store initiator FSM; define MEM_TRACE_EN to print acked writes
module mem_ls_ctrl
    import mem_ls_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cpu_pc,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_type,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    ls_state_e         state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [2:0]        type_q, type_d;
    logic [1:0]        addr_lo_q, addr_lo_d;

    logic              al_misaligned;
    logic [3:0]        al_be;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_ld_data;

    mem_ls_ctrl_ls_align u_align (
        .req_type    (cpu_type),
        .req_we      (cpu_we),
        .req_addr_lo (cpu_addr[1:0]),
        .req_data    (cpu_wdata),
        .misaligned  (al_misaligned),
        .be          (al_be),
        .wdata       (al_wdata),
        .ld_type     (type_q),
        .ld_addr_lo  (addr_lo_q),
        .rdata       (mem_rdata),
        .ld_data     (al_ld_data)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        type_d      = type_q;
        addr_lo_d   = addr_lo_q;
        cpu_stall   = 1'b0;
        cpu_err     = 1'b0;
        cpu_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (al_misaligned) begin
                        cpu_err = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        cpu_stall   = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = cpu_we;
                        mem_addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = al_be;
                        mem_wdata_d = al_wdata;
                        type_d      = cpu_type;
                        addr_lo_d   = cpu_addr[1:0];
                    end
                end
            end
            ST_REQ: begin
                cpu_stall = 1'b1;
                if (mem_ack) begin
                    cpu_rdata_d = al_ld_data;
                    mem_req_d   = 1'b0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                // cpu_req is still high here; only IDLE may accept the next access.
                cpu_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            type_q      <= LS_W;
            addr_lo_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            type_q      <= type_d;
            addr_lo_q   <= addr_lo_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rdata = cpu_rdata_q;

`ifdef MEM_TRACE_EN
    logic [31:0] pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else if (state_q == ST_IDLE && cpu_req && !al_misaligned) begin
            pc_q <= cpu_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && state_q == ST_REQ && mem_ack && mem_we_q) begin
            $display("@%h: *%h <= %h", pc_q, mem_addr_q, mem_wdata_q);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^cpu_pc;
`endif

endmodule

// File: tb/tb_mem_ls_ctrl.sv
// tb/tb_mem_ls_ctrl.sv - scoreboard bench for the load/store controller
module tb_mem_ls_ctrl;
    import mem_ls_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cpu_pc = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [2:0]  cpu_type = LS_W;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_stall, cpu_done, cpu_err;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] rword;
    } mem_exp_t;

    mem_exp_t    mem_q[$];
    logic [31:0] rd_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    mem_ls_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_pc    (cpu_pc),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_type  (cpu_type),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_type  = t;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_pc    = cpu_pc + 32'd4;
    endtask

    // Plays the memory: checks mem_* against the queue head every request cycle, acks after 'waits' cycles.
    task automatic run_txn(input int waits, input bit is_load, input string nm);
        int          w = 0;
        int          stall_n = 0;
        bit          fin = 1'b0;
        mem_exp_t    e;
        logic [31:0] er;
        for (int c = 0; c < 50 && !fin; c++) begin
            @(negedge clk);
            if (cpu_stall) stall_n++;
            if (cpu_done) begin
                fin = 1'b1;
                if (is_load) begin
                    er = rd_q.pop_front();
                    n_cmp++;
                    if (cpu_rdata !== er) begin
                        n_err++;
                        $display("FAIL %s rdata: got %h required %h", nm, cpu_rdata, er);
                    end
                end
            end
            if (mem_req) begin
                if (mem_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL %s unexpected mem_req: got 1 required 0", nm);
                end else begin
                    e = mem_q[0];
                    n_cmp++;
                    if ({mem_addr, mem_be, mem_wdata, mem_we} !== {e.addr, e.be, e.wdata, e.we}) begin
                        n_err++;
                        $display("FAIL %s mem: got addr=%h be=%b wdata=%h we=%b required addr=%h be=%b wdata=%h we=%b",
                                 nm, mem_addr, mem_be, mem_wdata, mem_we, e.addr, e.be, e.wdata, e.we);
                    end
                    if (w == waits) begin
                        void'(mem_q.pop_front());
                        mem_ack   = 1'b1;
                        mem_rdata = e.rword;
                    end else begin
                        w++;
                    end
                end
            end
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (fin) cpu_req = 1'b0;
        end
        n_cmp++;
        if (!fin) begin
            n_err++;
            cpu_req = 1'b0;
            $display("FAIL %s timeout: got no cpu_done required one", nm);
        end
        n_cmp++;
        if (stall_n != 2 + waits) begin
            n_err++;
            $display("FAIL %s stall cycles: got %0d required %0d", nm, stall_n, 2 + waits);
        end
        @(negedge clk);
        n_cmp++;
        if ({cpu_done, cpu_stall, mem_req} !== 3'b000) begin
            n_err++;
            $display("FAIL %s after done: got done/stall/req=%b required 000", nm, {cpu_done, cpu_stall, mem_req});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, cpu_rdata, cpu_done, cpu_stall, cpu_err} !== '0) begin
            n_err++;
            $display("FAIL reset outputs: got req=%b we=%b addr=%h be=%b wdata=%h rdata=%h done=%b required all zero",
                     mem_req, mem_we, mem_addr, mem_be, mem_wdata, cpu_rdata, cpu_done);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_store_word();
        mem_q.push_back('{addr: 32'h10, be: 4'b1111, wdata: 32'h12345678, we: 1'b1, rword: 32'h0});
        drive(1'b1, LS_W, 32'h10, 32'h12345678);
        run_txn(1, 1'b0, "sw");
    endtask

    task automatic test_store_sub();
        mem_q.push_back('{addr: 32'h10, be: 4'b1000, wdata: 32'hABABABAB, we: 1'b1, rword: 32'h0});
        drive(1'b1, LS_B, 32'h13, 32'h123456AB);
        run_txn(0, 1'b0, "sb");
        mem_q.push_back('{addr: 32'h10, be: 4'b1100, wdata: 32'hBEEFBEEF, we: 1'b1, rword: 32'h0});
        drive(1'b1, LS_H, 32'h12, 32'h5555BEEF);
        run_txn(2, 1'b0, "sh");
    endtask

    task automatic test_loads();
        logic [2:0]  tt[7]   = '{LS_B, LS_BU, LS_H, LS_HU, LS_W, LS_B, LS_HU};
        logic [31:0] ta[7]   = '{32'h1, 32'h1, 32'h2, 32'h2, 32'h4, 32'h103, 32'h200};
        logic [31:0] tw[7]   = '{32'h00008000, 32'h00008000, 32'h80010000, 32'h80010000,
                                 32'hCAFEF00D, 32'h7F000000, 32'h1234FFFF};
        logic [31:0] tma[7]  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h100, 32'h200};
        logic [3:0]  tbe[7]  = '{4'b0010, 4'b0010, 4'b1100, 4'b1100, 4'b1111, 4'b1000, 4'b0011};
        logic [31:0] trd[7]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001,
                                 32'hCAFEF00D, 32'h0000007F, 32'h0000FFFF};
        for (int i = 0; i < 7; i++) begin
            mem_q.push_back('{addr: tma[i], be: tbe[i], wdata: 32'h0, we: 1'b0, rword: tw[i]});
            rd_q.push_back(trd[i]);
            drive(1'b0, tt[i], ta[i], 32'hDEADBEEF);
            run_txn(i % 3, 1'b1, $sformatf("load%0d", i));
            last_rd = trd[i];
        end
    endtask

    task automatic test_misaligned();
        logic [2:0]  tt[4] = '{LS_W, LS_H, LS_HU, LS_W};
        logic [31:0] ta[4] = '{32'h6, 32'h3, 32'h1, 32'h1};
        logic        twe[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(twe[i], tt[i], ta[i], 32'hFFFFFFFF);
            @(negedge clk);
            n_cmp++;
            if ({cpu_err, cpu_stall, mem_req} !== 3'b100) begin
                n_err++;
                $display("FAIL misalign%0d: got err/stall/req=%b required 100", i, {cpu_err, cpu_stall, mem_req});
            end
            @(posedge clk);
            #1;
            cpu_req = 1'b0;
            repeat (2) begin
                @(negedge clk);
                n_cmp++;
                if ({cpu_err, mem_req, cpu_done} !== 3'b000) begin
                    n_err++;
                    $display("FAIL misalign%0d after: got err/req/done=%b required 000", i, {cpu_err, mem_req, cpu_done});
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ack_ignored();
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A5A5A;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if ({cpu_done, mem_req} !== 2'b00 || cpu_rdata !== last_rd) begin
                n_err++;
                $display("FAIL stray ack: got done/req=%b rdata=%h required 00 rdata=%h", {cpu_done, mem_req}, cpu_rdata, last_rd);
            end
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        mem_q.push_back('{addr: 32'h20, be: 4'b1111, wdata: 32'h0, we: 1'b0, rword: 32'h0BADF00D});
        rd_q.push_back(32'h0BADF00D);
        drive(1'b0, LS_W, 32'h20, 32'h0);
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = mem_req;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL reset_mid req: got mem_req=0 required 1");
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req, cpu_done} !== 2'b00 || cpu_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid async: got req/done=%b rdata=%h required 00 rdata=00000000", {mem_req, cpu_done}, cpu_rdata);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, cpu_done} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_mid hold: got req/done=%b required 00", {mem_req, cpu_done});
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_txn(1, 1'b1, "reset_mid restart");
    endtask

    initial begin
        test_reset();
        @(posedge clk);
        #1;
        test_store_word();
        test_store_sub();
        test_loads();
        test_misaligned();
        test_ack_ignored();
        test_reset_mid();
        n_cmp++;
        if (mem_q.size() != 0 || rd_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: got %0d/%0d left required 0/0", mem_q.size(), rd_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
